// File: rtl/pipe_stage_pkg.sv
// Shared types and stage codes for the stage-2 reduction pipe sequencer.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } seq_state_e;

  localparam logic [2:0] STAGE_DONE   = 3'd7;
  localparam logic [2:0] STAGE_NORM   = 3'd4;
  localparam logic [2:0] STAGE_MAXCOS = 3'd5;
  localparam logic [2:0] STAGE_THR    = 3'd6;
  // Stage whose reconfigurable tile runs in the alternate mode.
  localparam logic [2:0] STAGE_RECONF = 3'd1;

endpackage

// File: rtl/pipe_stage_sequencer_stage_next_sel.sv
// Priority pick of the lowest non-empty stage at or above from_stage.
module stage_next_sel
  import pipe_stage_pkg::*;
#(
  parameter int NUM_STAGES = 7
) (
  input  logic [NUM_STAGES-1:0] nz_mask,
  input  logic [2:0]            from_stage,
  output logic                  found,
  output logic [2:0]            next_stage
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    found      = 1'b0;
    next_stage = STAGE_DONE;
    // Descending scan: the last hit written is the lowest qualifying stage.
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (nz_mask[s] && (3'(s) >= from_stage)) begin
        found      = 1'b1;
        next_stage = 3'(s);
      end
    end
  end

endmodule

// File: rtl/pipe_stage_sequencer.sv
// Programmable stage walk for the div/mul/sqrt/cmp reduction pipe with beat handshake.
module pipe_stage_sequencer
  import pipe_stage_pkg::*;
#(
  parameter int NUM_STAGES = 7,
  parameter int CNT_W      = 8
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_addr_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  input  logic             stall_i,
  output logic             in_ready_o,
  output logic             busy_o,
  output logic [2:0]       stage_o,
  output logic [CNT_W-1:0] step_o,
  output logic             first_o,
  output logic             last_o,
  output logic             mode_o,
  output logic             finished_o
);

  seq_state_e       state_q;
  logic [2:0]       stage_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] len_q [NUM_STAGES];

  logic                  run;
  logic                  wr_en;
  logic                  beat;
  logic                  is_last;
  logic [CNT_W-1:0]      cur_len;
  logic [NUM_STAGES-1:0] nz_mask;
  logic [2:0]            from_stage;
  logic                  next_found;
  logic [2:0]            next_stage;

  assign run   = (state_q == S_RUN);
  assign wr_en = (state_q == S_IDLE) && cfg_we_i && (cfg_addr_i != STAGE_DONE);
  assign beat  = run && in_valid_i && !stall_i;

  // A write in the same cycle as start is folded in so the pass sees the new length.
  always_comb begin
    nz_mask = '0;
    cur_len = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      nz_mask[s] = (wr_en && (cfg_addr_i == 3'(s))) ? (cfg_len_i != '0) : (len_q[s] != '0);
      if (stage_q == 3'(s)) cur_len = len_q[s];
    end
  end

  // Only non-empty stages are ever entered, so cur_len >= 1 whenever this matters.
  assign is_last    = (step_q == cur_len - CNT_W'(1));
  assign from_stage = run ? stage_q + 3'd1 : 3'd0;

  stage_next_sel #(.NUM_STAGES(NUM_STAGES)) u_next_sel (
    .nz_mask    (nz_mask),
    .from_stage (from_stage),
    .found      (next_found),
    .next_stage (next_stage)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the length regfile is reset on purpose; a reset must leave every stage skipped.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= S_IDLE;
      stage_q <= STAGE_DONE;
      step_q  <= '0;
      for (int s = 0; s < NUM_STAGES; s++) len_q[s] <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      stage_q <= STAGE_DONE;
      step_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          for (int s = 0; s < NUM_STAGES; s++) begin
            if (wr_en && (cfg_addr_i == 3'(s))) len_q[s] <= cfg_len_i;
          end
          if (start_i) begin
            step_q  <= '0;
            state_q <= next_found ? S_RUN : S_DONE;
            stage_q <= next_stage;
          end
        end
        S_RUN: begin
          if (beat) begin
            if (is_last) begin
              step_q  <= '0;
              stage_q <= next_stage;
              if (!next_found) state_q <= S_DONE;
            end else begin
              step_q <= step_q + CNT_W'(1);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o = run && !stall_i;
  assign busy_o     = (state_q != S_IDLE);
  assign stage_o    = stage_q;
  assign step_o     = step_q;
  assign first_o    = run && (step_q == '0);
  assign last_o     = run && is_last;
  assign mode_o     = !(run && (stage_q == STAGE_RECONF));
  assign finished_o = (state_q == S_DONE);

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// Self-checking bench: directed tables, hand sequences and a queue-based reference model.
module tb_pipe_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       stall = 1'b0;
  logic       in_ready, busy, first, last, mode, finished;
  logic [2:0] stage;
  logic [7:0] step;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_sequencer #(.NUM_STAGES(7), .CNT_W(8)) dut (
    .CLK_i      (clk),
    .RST_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_len_i  (cfg_len),
    .start_i    (start),
    .abort_i    (abort),
    .in_valid_i (in_valid),
    .stall_i    (stall),
    .in_ready_o (in_ready),
    .busy_o     (busy),
    .stage_o    (stage),
    .step_o     (step),
    .first_o    (first),
    .last_o     (last),
    .mode_o     (mode),
    .finished_o (finished)
  );

  function automatic logic [16:0] pk(bit r, bit b, logic [2:0] s, logic [7:0] k,
                                     bit f, bit l, bit m, bit fin);
    return {r, b, s, k, f, l, m, fin};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {in_ready, busy, stage, step, first, last, mode, finished};
  endfunction

  localparam logic [16:0] IDLE_V = {1'b0, 1'b0, 3'd7, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [16:0] DONE_V = {1'b0, 1'b1, 3'd7, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_in(bit st, bit v, bit sl, bit ab, bit we, logic [2:0] a, logic [7:0] l);
    start = st; in_valid = v; stall = sl; abort = ab;
    cfg_we = we; cfg_addr = a; cfg_len = l;
  endtask

  // ---------------- reference model: a pass is a queue of (stage, step) beats
  int m_len[7];
  bit m_run, m_done;
  int q_stage[$];
  int q_step[$];

  task automatic model_clear();
    foreach (m_len[i]) m_len[i] = 0;
    m_run = 0; m_done = 0;
    q_stage.delete(); q_step.delete();
  endtask

  function automatic logic [16:0] model_exp(bit sl);
    int s, k;
    if (m_done) return DONE_V;
    if (m_run) begin
      s = q_stage[0]; k = q_step[0];
      return pk(!sl, 1'b1, 3'(s), 8'(k), k == 0, k == m_len[s] - 1, s != 1, 1'b0);
    end
    return IDLE_V;
  endfunction

  task automatic model_edge();
    if (abort) begin
      m_run = 0; m_done = 0; q_stage.delete(); q_step.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (in_valid && !stall) begin
        void'(q_stage.pop_front()); void'(q_step.pop_front());
        if (q_stage.size() == 0) begin m_run = 0; m_done = 1; end
      end
    end else begin
      if (cfg_we && cfg_addr != 3'd7) m_len[cfg_addr] = int'(cfg_len);
      if (start) begin
        for (int s = 0; s < 7; s++)
          for (int k = 0; k < m_len[s]; k++) begin q_stage.push_back(s); q_step.push_back(k); end
        if (q_stage.size() == 0) m_done = 1; else m_run = 1;
      end
    end
  endtask

  // One model-checked cycle: drive at negedge, compare 2ns later, advance model, wait next negedge.
  task automatic mcycle(string name, bit st, bit v, bit sl, bit ab, bit we,
                        logic [2:0] a, logic [7:0] l);
    set_in(st, v, sl, ab, we, a, l);
    #2;
    check(name, 32'(dut_vec()), 32'(model_exp(sl)));
    model_edge();
    @(negedge clk);
  endtask

  task automatic reset_both();
    set_in(0, 0, 0, 0, 0, 3'd0, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_s1();
    int lens[7] = '{3, 2, 0, 1, 0, 0, 2};
    for (int s = 0; s < 7; s++) mcycle("cfg_wr", 0, 0, 0, 0, 1, 3'(s), 8'(lens[s]));
  endtask

  // ---------------- scenario 1 table
  typedef struct {
    bit          st, v, sl, ab;
    logic [16:0] exp;
  } row_t;
  row_t tbl[11];

  task automatic apply_table(string name);
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].st, tbl[i].v, tbl[i].sl, tbl[i].ab, 0, 3'd0, 8'd0);
      #2;
      check($sformatf("%s_row%0d", name, i), 32'(dut_vec()), 32'(tbl[i].exp));
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin_at;
    tbl[0]  = '{1, 0, 0, 0, IDLE_V};
    tbl[1]  = '{0, 1, 0, 0, pk(1, 1, 3'd0, 8'd0, 1, 0, 1, 0)};
    tbl[2]  = '{0, 1, 0, 0, pk(1, 1, 3'd0, 8'd1, 0, 0, 1, 0)};
    tbl[3]  = '{0, 1, 0, 0, pk(1, 1, 3'd0, 8'd2, 0, 1, 1, 0)};
    tbl[4]  = '{0, 1, 0, 0, pk(1, 1, 3'd1, 8'd0, 1, 0, 0, 0)};
    tbl[5]  = '{0, 1, 0, 0, pk(1, 1, 3'd1, 8'd1, 0, 1, 0, 0)};
    tbl[6]  = '{0, 1, 0, 0, pk(1, 1, 3'd3, 8'd0, 1, 1, 1, 0)};
    tbl[7]  = '{0, 1, 0, 0, pk(1, 1, 3'd6, 8'd0, 1, 0, 1, 0)};
    tbl[8]  = '{0, 1, 0, 0, pk(1, 1, 3'd6, 8'd1, 0, 1, 1, 0)};
    tbl[9]  = '{0, 0, 0, 0, DONE_V};
    tbl[10] = '{0, 0, 0, 0, IDLE_V};

    // Reset state
    model_clear();
    #1 rst = 1'b1;
    #2 check("reset_state", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: nominal walk, finished on the 10th cycle counting the start cycle
    cfg_s1();
    apply_table("s1");

    // Scenario 5: abort in stage 3 together with a cfg write; lengths must survive
    set_in(1, 0, 0, 0, 0, 3'd0, 8'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 0, 0, 0, 3'd0, 8'd0);
      @(negedge clk);
    end
    set_in(0, 1, 0, 1, 1, 3'd0, 8'd9);
    #2 check("s5_in_stage3", 32'(dut_vec()), 32'(pk(1, 1, 3'd3, 8'd0, 1, 1, 1, 0)));
    @(negedge clk);
    set_in(0, 1, 0, 0, 0, 3'd0, 8'd0);
    #2 check("s5_idle_after_abort", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);
    #2 check("s5_no_finished", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);
    apply_table("s5_restart");

    // Scenario 2: four stall cycles mid stage 1 stretch the pass by four cycles
    reset_both();
    cfg_s1();
    mcycle("s2_start", 1, 0, 0, 0, 0, 3'd0, 8'd0);
    fin_at = -1;
    for (int i = 0; i < 40 && fin_at < 0; i++) begin
      if (finished === 1'b1) fin_at = i;
      mcycle("s2_walk", 0, 1, (i >= 4 && i < 8), 0, 0, 3'd0, 8'd0);
    end
    check("s2_finish_cycle", 32'(fin_at), 32'd12);

    // Scenario 3: every stage empty -> straight to DONE, never ready
    reset_both();
    set_in(1, 1, 0, 0, 0, 3'd0, 8'd0);
    #2 check("s3_start_idle", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);
    set_in(0, 1, 0, 0, 0, 3'd0, 8'd0);
    #2 check("s3_done", 32'(dut_vec()), 32'(DONE_V));
    @(negedge clk);
    #2 check("s3_back_idle", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);

    // Scenario 4: maximum length, no wrap, last only on step 254
    reset_both();
    mcycle("s4_cfg", 0, 0, 0, 0, 1, 3'd0, 8'd255);
    mcycle("s4_start", 1, 0, 0, 0, 0, 3'd0, 8'd0);
    for (int i = 0; i < 258; i++) mcycle("s4_walk", 0, 1, 0, 0, 0, 3'd0, 8'd0);

    // Scenario 6: async reset in stage 1 clears outputs immediately and wipes lengths
    reset_both();
    cfg_s1();
    mcycle("s6_start", 1, 0, 0, 0, 0, 3'd0, 8'd0);
    for (int i = 0; i < 4; i++) mcycle("s6_walk", 0, 1, 0, 0, 0, 3'd0, 8'd0);
    set_in(0, 1, 0, 0, 0, 3'd0, 8'd0);
    #2 check("s6_mode_stage1", 32'(dut_vec()), 32'(pk(1, 1, 3'd1, 8'd1, 0, 1, 0, 0)));
    #1 rst = 1'b1;
    #1 check("s6_async_reset", 32'(dut_vec()), 32'(IDLE_V));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    set_in(1, 1, 0, 0, 0, 3'd0, 8'd0);
    @(negedge clk);
    set_in(0, 1, 0, 0, 0, 3'd0, 8'd0);
    #2 check("s6_len_cleared", 32'(dut_vec()), 32'(DONE_V));
    @(negedge clk);

    // Randomised traffic against the reference model
    reset_both();
    for (int i = 0; i < 600; i++) begin
      mcycle("rand",
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) == 0,
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
